bubsys_nvram_upload: RTL and testbench
======================================

Name: bubsys_nvram_upload

Overview:
- Serves core-side RAM contents to hps_io over the ioctl upload path. This is the core-to-HPS direction of the ioctl interface; ROM download runs the other way.
- Used for the Bubble System save/hiscore RAM.
- Answers HPS read strobes with registered data and stretches them with ioctl_wait.
- Tracks writes to the RAM and raises an autosave request once the game has stopped writing for a quiet period.

Parameters:
- AW, 13: RAM address width; the image is 2^AW bytes.
- INDEX, 16'd4: ioctl_index value that selects this block.
- RAM_LAT, 1: read latency of the attached synchronous RAM, 1..3 cycles.
- QUIET_CYCLES, 72000000: write-free cycles before an autosave request (1 s at 72 MHz).

Ports:
- i_EMU_MCLK  in  1  system clock, 72 MHz
- i_EMU_INITRST_n  in  1  asynchronous active-low reset
- ioctl_upload  in  1  HPS upload in progress
- ioctl_index  in  16  upload target index
- ioctl_addr  in  27  byte address requested by HPS
- ioctl_rd  in  1  one-cycle read strobe
- ioctl_din  out  8  upload data to HPS
- ioctl_wait  out  1  stall to HPS; ORed externally with the download wait
- ioctl_upload_req  out  1  autosave request to hps_io
- o_RAM_RD  out  1  RAM read enable
- o_RAM_ADDR  out  AW  RAM read address
- i_RAM_DATA  in  8  RAM read data, valid RAM_LAT cycles after o_RAM_RD
- i_RAM_WR_MON  in  1  game-side RAM write strobe
- i_UPLOAD_EN  in  1  OSD autosave enable
- o_BUSY  out  1  FSM not in IDLE

Behaviour:
- Clock and reset: one clock, i_EMU_MCLK. Reset i_EMU_INITRST_n is asynchronous, active-low.
- Reset values: all outputs 0, FSM in IDLE, dirty=0, quiet counter=0.
- sel = ioctl_upload && (ioctl_index == INDEX).
- FSM states: IDLE, FETCH, LAT, DONE.
  - IDLE: on ioctl_rd && sel, register the address, set ioctl_wait=1 next cycle and go to FETCH.
  - FETCH: o_RAM_RD=1 for exactly one cycle, o_RAM_ADDR=addr[AW-1:0]. Go to LAT with latency counter = RAM_LAT-1.
  - LAT: count down to 0, then go to DONE.
  - DONE: capture i_RAM_DATA into ioctl_din, clear ioctl_wait, return to IDLE.
- Latency: ioctl_rd to ioctl_wait low is RAM_LAT+2 cycles. ioctl_din is stable from the cycle wait drops until the next accepted read.
- Out-of-range address (addr ≥ 2^AW, checksum bytes excepted): no RAM access. ioctl_din=8'hFF, wait held for one cycle only.
- ioctl_rd while not IDLE: ignored, as HPS holds off during wait.
- ioctl_rd while sel=0: ignored, and outputs are unchanged.
- sel falling mid-operation: abort to IDLE next cycle. ioctl_wait=0, o_RAM_RD=0, ioctl_din keeps its old value.
- Dirty flag and quiet counter:
  - i_RAM_WR_MON sets dirty and zeroes the quiet counter.
  - The quiet counter otherwise increments, saturating at QUIET_CYCLES-1.
  - The rising edge of sel clears dirty. A write in the same cycle wins, so dirty stays 1.
  - Writes during an upload set dirty again, so another save follows.
- Autosave request:
  - ioctl_upload_req goes to 1 when dirty, counter saturated, i_UPLOAD_EN=1 and ioctl_upload=0.
  - It is held until ioctl_upload rises, then cleared.
  - If i_UPLOAD_EN drops while req is pending, req is cleared.
- Counter width: $clog2(QUIET_CYCLES).

Optional Feature:
- Macro: BUBSYS_NVRAM_CHECKSUM_EN.
- Defined:
  - A running 16-bit sum of every byte written to ioctl_din from RAM is kept. It is reset on the rising edge of sel.
  - Address 2^AW returns sum[7:0]; 2^AW+1 returns sum[15:8]. Both return with one wait cycle.
  - Addresses above 2^AW+1 return 8'hFF.
- Undefined: no sum logic; every address ≥ 2^AW returns 8'hFF.

Decomposition:
- Shared package bubsys_pkg holds:
  - the FSM state enum;
  - the INDEX constant shared with the download path;
  - the OOR fill byte 8'hFF.
- One natural sub-module: bubsys_quiet_timer, containing the dirty flag, quiet counter and request handshake. The FSM stays in the top.

Test Plan:
- Reset release, RAM[0x0010]=8'h5A, sel=1, ioctl_rd at addr 0x10 → o_RAM_RD pulses one cycle with addr 0x10. ioctl_wait high for 3 cycles (RAM_LAT=1). ioctl_din=8'h5A when wait drops.
- ioctl_rd at addr 0x2000 (AW=13) → no o_RAM_RD, one wait cycle, ioctl_din=8'hFF. With the macro defined and RAM bytes summing to 0x1234: addr 0x2000 → 8'h34, addr 0x2001 → 8'h12.
- ioctl_index=16'd0 with ioctl_rd → no wait, no RAM read, ioctl_din unchanged.
- ioctl_upload dropped during LAT → next cycle: FSM IDLE, ioctl_wait=0, o_BUSY=0.
- QUIET_CYCLES=100, one i_RAM_WR_MON pulse, i_UPLOAD_EN=1 → ioctl_upload_req rises 100 cycles later. It stays high until ioctl_upload=1 with matching index, then clears. A write 50 cycles after the pulse restarts the count.
- Write coinciding with the sel rising edge → dirty remains 1. A new request follows after the upload ends plus QUIET_CYCLES.

Source files
------------

// File: rtl/bubsys_pkg.sv
// Shared definitions for the Bubble System NVRAM upload path: the upload FSM
// states, the ioctl index of the NVRAM image and the byte returned for
// addresses outside the RAM image.
package bubsys_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_LAT   = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // ioctl_index of the NVRAM image, also used by the download path.
  localparam logic [15:0] NVRAM_INDEX = 16'd4;

  // Byte returned for reads that do not map onto RAM.
  localparam logic [7:0] OOR_FILL = 8'hFF;

endpackage

// File: rtl/bubsys_quiet_timer.sv
// Autosave timing for the NVRAM: a dirty flag set by game writes, a
// write-free cycle counter and the request handshake towards hps_io.
module bubsys_quiet_timer #(
  parameter int QUIET_CYCLES = 72000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic wr,
  input  logic sel_rise,
  input  logic upload,
  input  logic upload_en,
  output logic req
);

  localparam int CW = (QUIET_CYCLES > 2) ? $clog2(QUIET_CYCLES) : 1;
  localparam logic [CW-1:0] SAT = CW'(QUIET_CYCLES - 1);

  logic          dirty;
  logic [CW-1:0] quiet_cnt;
  logic          quiet;

  assign quiet = (quiet_cnt == SAT);

  // Dirty flag: a write wins over the upload start that would clear it, so a
  // write landing on the first upload cycle still triggers another save.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dirty <= 1'b0;
    end else if (wr) begin
      dirty <= 1'b1;
    end else if (sel_rise) begin
      dirty <= 1'b0;
    end
  end

  // Write-free cycle counter, saturating once the quiet period is reached.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      quiet_cnt <= '0;
    end else if (wr) begin
      quiet_cnt <= '0;
    end else if (!quiet) begin
      quiet_cnt <= quiet_cnt + 1'b1;
    end
  end

  // Request stays up until hps_io starts an upload or autosave is disabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req <= 1'b0;
    end else if (!upload_en || upload) begin
      req <= 1'b0;
    end else if (dirty && quiet) begin
      req <= 1'b1;
    end
  end

endmodule

// File: rtl/bubsys_nvram_upload.sv
// NVRAM upload (core -> HPS) for the Bubble System save/hiscore RAM.
// HPS read strobes are answered with registered data while ioctl_wait stalls
// the HPS until the RAM word has been fetched. Addresses beyond the image
// return a fill byte with a single wait cycle.
// Optional feature macro: BUBSYS_NVRAM_CHECKSUM_EN -- when defined, the two
// bytes just past the image return a running 16-bit sum of uploaded bytes.
//
// Handshake: ioctl_rd is a one-cycle strobe accepted only in IDLE while this
// block is selected; ioctl_wait rises the following cycle and falls in the
// same cycle ioctl_din takes the new byte, which then holds until the next
// accepted read. Deselecting mid-read aborts without touching ioctl_din.
module bubsys_nvram_upload
  import bubsys_pkg::*;
#(
  parameter int          AW           = 13,
  parameter logic [15:0] INDEX        = NVRAM_INDEX,
  parameter int          RAM_LAT      = 1,
  parameter int          QUIET_CYCLES = 72000000
) (
  input  logic          i_EMU_MCLK,
  input  logic          i_EMU_INITRST_n,
  input  logic          ioctl_upload,
  input  logic [15:0]   ioctl_index,
  input  logic [26:0]   ioctl_addr,
  input  logic          ioctl_rd,
  output logic [7:0]    ioctl_din,
  output logic          ioctl_wait,
  output logic          ioctl_upload_req,
  output logic          o_RAM_RD,
  output logic [AW-1:0] o_RAM_ADDR,
  input  logic [7:0]    i_RAM_DATA,
  input  logic          i_RAM_WR_MON,
  input  logic          i_UPLOAD_EN,
  output logic          o_BUSY
);

  localparam logic [26:0] RAM_SIZE = 27'(1) << AW;
  localparam logic [1:0]  LAT_INIT = 2'(RAM_LAT - 1);

  state_t        state;
  state_t        state_nxt;
  logic          sel;
  logic          sel_q;
  logic          sel_rise;
  logic          in_range;
  logic [AW-1:0] addr_q;
  logic          oor_q;
  logic [1:0]    lat_cnt;
  logic          wait_q;
  logic [7:0]    din_q;
  logic [7:0]    fill_byte;

  assign sel      = ioctl_upload && (ioctl_index == INDEX);
  assign sel_rise = sel && !sel_q;
  assign in_range = (ioctl_addr < RAM_SIZE);

`ifdef BUBSYS_NVRAM_CHECKSUM_EN
  logic [15:0] sum;
  logic        csum_lo_q;
  logic        csum_hi_q;

  // Running sum of RAM bytes handed to HPS, restarted with each upload.
  always_ff @(posedge i_EMU_MCLK or negedge i_EMU_INITRST_n) begin
    if (!i_EMU_INITRST_n) begin
      sum       <= '0;
      csum_lo_q <= 1'b0;
      csum_hi_q <= 1'b0;
    end else begin
      if (sel_rise) begin
        sum <= '0;
      end else if (state == ST_DONE && sel && !oor_q) begin
        sum <= sum + {8'd0, i_RAM_DATA};
      end
      if (state == ST_IDLE && ioctl_rd && sel) begin
        csum_lo_q <= (ioctl_addr == RAM_SIZE);
        csum_hi_q <= (ioctl_addr == 27'(RAM_SIZE + 27'd1));
      end
    end
  end

  assign fill_byte = csum_lo_q ? sum[7:0] :
                     csum_hi_q ? sum[15:8] : OOR_FILL;
`else
  assign fill_byte = OOR_FILL;
`endif

  // State register.
  always_ff @(posedge i_EMU_MCLK or negedge i_EMU_INITRST_n) begin
    if (!i_EMU_INITRST_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state: out-of-image reads skip the RAM; deselect aborts any read.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (ioctl_rd && sel) state_nxt = in_range ? ST_FETCH : ST_DONE;
      ST_FETCH: state_nxt = ST_LAT;
      ST_LAT:   if (lat_cnt == 2'd0) state_nxt = ST_DONE;
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
    if (state != ST_IDLE && !sel) begin
      state_nxt = ST_IDLE;
    end
  end

  // Read datapath: address capture, latency count, wait and data registers.
  always_ff @(posedge i_EMU_MCLK or negedge i_EMU_INITRST_n) begin
    if (!i_EMU_INITRST_n) begin
      sel_q   <= 1'b0;
      addr_q  <= '0;
      oor_q   <= 1'b0;
      lat_cnt <= '0;
      wait_q  <= 1'b0;
      din_q   <= '0;
    end else begin
      sel_q <= sel;
      if (state != ST_IDLE && !sel) begin
        wait_q <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (ioctl_rd && sel) begin
              addr_q <= ioctl_addr[AW-1:0];
              oor_q  <= !in_range;
              wait_q <= 1'b1;
            end
          end
          ST_FETCH: lat_cnt <= LAT_INIT;
          ST_LAT: begin
            if (lat_cnt != 2'd0) lat_cnt <= lat_cnt - 2'd1;
          end
          ST_DONE: begin
            din_q  <= oor_q ? fill_byte : i_RAM_DATA;
            wait_q <= 1'b0;
          end
          default: ;
        endcase
      end
    end
  end

  assign ioctl_din  = din_q;
  assign ioctl_wait = wait_q;
  assign o_RAM_RD   = (state == ST_FETCH);
  assign o_RAM_ADDR = addr_q;
  assign o_BUSY     = (state != ST_IDLE);

  bubsys_quiet_timer #(
    .QUIET_CYCLES(QUIET_CYCLES)
  ) u_quiet_timer (
    .clk       (i_EMU_MCLK),
    .rst_n     (i_EMU_INITRST_n),
    .wr        (i_RAM_WR_MON),
    .sel_rise  (sel_rise),
    .upload    (ioctl_upload),
    .upload_en (i_UPLOAD_EN),
    .req       (ioctl_upload_req)
  );

endmodule

// File: tb/tb_bubsys_nvram_upload.sv
// Bench for bubsys_nvram_upload: RAM model, read driver, expected-byte queue,
// a timestamp-based autosave reference and a final report.
`timescale 1ns/1ps
module tb_bubsys_nvram_upload;
  localparam int          AW       = 13;
  localparam int          RAM_LAT  = 1;
  localparam int          QUIET    = 100;
  localparam logic [15:0] IDX      = 16'd4;
  localparam int          RAM_SIZE = 1 << AW;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          ioctl_upload = 1'b0;
  logic [15:0]   ioctl_index = 16'd0;
  logic [26:0]   ioctl_addr = '0;
  logic          ioctl_rd = 1'b0;
  logic [7:0]    ioctl_din;
  logic          ioctl_wait;
  logic          ioctl_upload_req;
  logic          o_RAM_RD;
  logic [AW-1:0] o_RAM_ADDR;
  logic [7:0]    i_RAM_DATA;
  logic          i_RAM_WR_MON = 1'b0;
  logic          i_UPLOAD_EN = 1'b0;
  logic          o_BUSY;

  int checks = 0;
  int failures = 0;

  logic [7:0] mem [RAM_SIZE];
  logic [7:0] ram_pipe [RAM_LAT];
  logic [7:0] exp_q[$];
`ifdef BUBSYS_NVRAM_CHECKSUM_EN
  logic [15:0] m_sum = '0;
`endif

  bubsys_nvram_upload #(
    .AW(AW), .INDEX(IDX), .RAM_LAT(RAM_LAT), .QUIET_CYCLES(QUIET)
  ) dut (
    .i_EMU_MCLK       (clk),
    .i_EMU_INITRST_n  (rst_n),
    .ioctl_upload     (ioctl_upload),
    .ioctl_index      (ioctl_index),
    .ioctl_addr       (ioctl_addr),
    .ioctl_rd         (ioctl_rd),
    .ioctl_din        (ioctl_din),
    .ioctl_wait       (ioctl_wait),
    .ioctl_upload_req (ioctl_upload_req),
    .o_RAM_RD         (o_RAM_RD),
    .o_RAM_ADDR       (o_RAM_ADDR),
    .i_RAM_DATA       (i_RAM_DATA),
    .i_RAM_WR_MON     (i_RAM_WR_MON),
    .i_UPLOAD_EN      (i_UPLOAD_EN),
    .o_BUSY           (o_BUSY)
  );

  // Synchronous RAM: data appears RAM_LAT edges after the read and then holds.
  always @(posedge clk) begin
    if (o_RAM_RD) ram_pipe[0] <= mem[o_RAM_ADDR];
    for (int i = 1; i < RAM_LAT; i++) ram_pipe[i] <= ram_pipe[i-1];
  end
  assign i_RAM_DATA = ram_pipe[RAM_LAT-1];

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  // Autosave reference: a request becomes due once the RAM is dirty and at
  // least QUIET edges have passed since the last write edge.
  wire ref_sel = ioctl_upload && (ioctl_index == IDX);
  longint cyc = 0;
  longint m_last_wr = -1000000;
  bit     m_dirty = 1'b0;
  bit     m_req = 1'b0;
  bit     m_sel_prev = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc <= 0; m_last_wr <= -1000000; m_dirty <= 1'b0; m_req <= 1'b0; m_sel_prev <= 1'b0;
    end else begin
      if (!i_UPLOAD_EN || ioctl_upload) m_req <= 1'b0;
      else if (m_dirty && (cyc - m_last_wr) >= QUIET) m_req <= 1'b1;
      if (i_RAM_WR_MON) begin
        m_dirty <= 1'b1; m_last_wr <= cyc;
      end else if (ref_sel && !m_sel_prev) begin
        m_dirty <= 1'b0;
      end
      m_sel_prev <= ref_sel;
      cyc <= cyc + 1;
    end
  end

  always @(negedge clk) begin
    if (rst_n) check("req_track", ioctl_upload_req, m_req);
  end

  // ---------------- driver tasks ----------------
  task automatic start_upload(input logic [15:0] idx);
    @(negedge clk);
    ioctl_index = idx;
    ioctl_upload = 1'b1;
`ifdef BUBSYS_NVRAM_CHECKSUM_EN
    if (idx == IDX) m_sum = '0;
`endif
  endtask

  task automatic wr_pulse();
    @(negedge clk); i_RAM_WR_MON = 1'b1;
    @(negedge clk); i_RAM_WR_MON = 1'b0;
  endtask

  // One HPS read with this block selected; checks data, wait length and RAM use.
  task automatic do_read(input logic [26:0] a);
    logic [7:0] e;
    int ew, er, nw, nr;
    if (a < RAM_SIZE) begin
      e = mem[a[AW-1:0]]; ew = RAM_LAT + 2; er = 1;
    end else begin
      e = 8'hFF; ew = 1; er = 0;
`ifdef BUBSYS_NVRAM_CHECKSUM_EN
      if (a == RAM_SIZE) e = m_sum[7:0];
      else if (a == RAM_SIZE + 1) e = m_sum[15:8];
`endif
    end
    exp_q.push_back(e);
    @(negedge clk); ioctl_addr = a; ioctl_rd = 1'b1;
    @(negedge clk); ioctl_rd = 1'b0;
    nw = 0; nr = 0;
    for (int k = 0; k < 20; k++) begin
      if (o_RAM_RD) begin
        nr++;
        check("ram_addr", o_RAM_ADDR, a[AW-1:0]);
      end
      if (!ioctl_wait) break;
      nw++;
      @(negedge clk);
    end
    check("wait_released", ioctl_wait, 1'b0);
    check("wait_cycles", nw, ew);
    check("ram_rd_pulses", nr, er);
    check("din", ioctl_din, exp_q.pop_front());
`ifdef BUBSYS_NVRAM_CHECKSUM_EN
    if (er == 1) m_sum = m_sum + {8'd0, e};
`endif
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog checks=%0d", checks);
    $fatal(1, "timeout");
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [7:0] old_din;
    logic [26:0] oor_list [4];
    int k;
    oor_list[0] = 27'(RAM_SIZE); oor_list[1] = 27'(RAM_SIZE + 1);
    oor_list[2] = 27'(RAM_SIZE + 2); oor_list[3] = 27'h7FF_FFFF;
    for (int i = 0; i < RAM_SIZE; i++) mem[i] = 8'($urandom_range(0, 255));
    mem[16'h0010] = 8'h5A;
    for (int i = 0; i < RAM_LAT; i++) ram_pipe[i] = 8'h00;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_din", ioctl_din, 8'h00);
    check("rst_wait", ioctl_wait, 1'b0);
    check("rst_req", ioctl_upload_req, 1'b0);
    check("rst_ram_rd", o_RAM_RD, 1'b0);
    check("rst_busy", o_BUSY, 1'b0);
    rst_n = 1'b1;
    i_UPLOAD_EN = 1'b1;
    repeat (2) @(negedge clk);

    // Directed read then randomized reads
    start_upload(IDX);
    do_read(27'h10);
    for (int i = 0; i < 24; i++) begin
      if ($urandom_range(0, 4) == 0) do_read(oor_list[$urandom_range(0, 3)]);
      else do_read(27'($urandom_range(0, RAM_SIZE - 1)));
    end
    do_read(27'(RAM_SIZE));
    do_read(27'(RAM_SIZE + 1));
    do_read(27'(RAM_SIZE + 2));

    // Foreign index: strobe ignored, outputs unchanged
    old_din = ioctl_din;
    @(negedge clk); ioctl_index = 16'd0;
    @(negedge clk); ioctl_addr = 27'h20; ioctl_rd = 1'b1;
    @(negedge clk); ioctl_rd = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("nosel_wait", ioctl_wait, 1'b0);
      check("nosel_ram_rd", o_RAM_RD, 1'b0);
      check("nosel_busy", o_BUSY, 1'b0);
      check("nosel_din", ioctl_din, old_din);
      @(negedge clk);
    end

    // Abort during the latency wait
    start_upload(IDX);
    do_read(27'($urandom_range(0, RAM_SIZE - 1)));
    old_din = ioctl_din;
    @(negedge clk); ioctl_addr = 27'h33; ioctl_rd = 1'b1;
    @(negedge clk); ioctl_rd = 1'b0;
    check("abort_fetch_busy", o_BUSY, 1'b1);
    @(negedge clk);
    check("abort_lat_wait", ioctl_wait, 1'b1);
    ioctl_upload = 1'b0;
    @(negedge clk);
    check("abort_wait", ioctl_wait, 1'b0);
    check("abort_busy", o_BUSY, 1'b0);
    check("abort_ram_rd", o_RAM_RD, 1'b0);
    check("abort_din", ioctl_din, old_din);

    // Autosave: a write 50 cycles in restarts the quiet period
    repeat (5) @(negedge clk);
    wr_pulse();
    repeat (48) @(negedge clk);
    check("req_early", ioctl_upload_req, 1'b0);
    wr_pulse();
    k = 0;
    for (int i = 1; i <= 3 * QUIET; i++) begin
      @(negedge clk);
      if (ioctl_upload_req) begin k = i; break; end
    end
    check("req_latency", k, QUIET);
    repeat (20) @(negedge clk);
    check("req_hold", ioctl_upload_req, 1'b1);

    // Upload starts together with a game write: dirty survives
    start_upload(IDX);
    i_RAM_WR_MON = 1'b1;
    @(negedge clk); i_RAM_WR_MON = 1'b0;
    check("req_cleared_by_upload", ioctl_upload_req, 1'b0);
    do_read(27'h10);
    @(negedge clk); ioctl_upload = 1'b0;
    k = 0;
    for (int i = 1; i <= 3 * QUIET; i++) begin
      @(negedge clk);
      if (ioctl_upload_req) begin k = i; break; end
    end
    check("req_after_upload", ioctl_upload_req, 1'b1);

    // Autosave disabled while pending clears the request
    @(negedge clk); i_UPLOAD_EN = 1'b0;
    @(negedge clk);
    check("req_en_drop", ioctl_upload_req, 1'b0);
    i_UPLOAD_EN = 1'b1;
    repeat (3) @(negedge clk);
    check("req_en_back", ioctl_upload_req, 1'b1);

    // Clean upload clears dirty: no further request
    start_upload(IDX);
    repeat (4) @(negedge clk);
    ioctl_upload = 1'b0;
    repeat (2 * QUIET) @(negedge clk);
    check("req_clean", ioctl_upload_req, 1'b0);

    // Random control traffic, checked every cycle by the reference
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      i_RAM_WR_MON = ($urandom_range(0, 60) == 0);
      if ($urandom_range(0, 150) == 0) i_UPLOAD_EN = ~i_UPLOAD_EN;
      if ($urandom_range(0, 120) == 0) begin
        ioctl_upload = ~ioctl_upload;
        ioctl_index = ($urandom_range(0, 3) == 0) ? 16'd7 : IDX;
      end
    end
    @(negedge clk);
    i_RAM_WR_MON = 1'b0;
    ioctl_upload = 1'b0;
    repeat (4) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
